// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : counter_pkg
//  Description : Shared constants and helpers for the counter family.
//  Revision    : 1.0 - initial release
// ============================================================================
package counter_pkg;

    // Range-end behaviour selectors for the SATURATE parameter
    localparam int MOD_COUNTER_MODE_WRAP = 0;
    localparam int MOD_COUNTER_MODE_SAT  = 1;

    // Bits needed to hold 0..n-1, never less than one bit
    function automatic int clog2_safe(input int n);
        int w;
        w = (n <= 1) ? 1 : $clog2(n);
        return w;
    endfunction

endpackage : counter_pkg
`default_nettype wire

// File: rtl/tick_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : tick_prescaler
//  Description : Counts enabled cycles 0..PRESCALE-1 and flags the last one.
//                tick is combinational from en so the owning counter steps
//                on the same edge the prescaler rolls over.
//  Revision    : 1.0 - initial release
// ============================================================================
module tick_prescaler
    import counter_pkg::*;
#(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic restart,
    output logic tick
);

    localparam int             c_W    = clog2_safe(PRESCALE);
    localparam logic [c_W-1:0] c_LAST = c_W'(PRESCALE - 1);
    localparam logic [c_W-1:0] c_ONE  = c_W'(1);

    logic [c_W-1:0] r_cnt;
    logic [c_W-1:0] w_cnt_nxt;

    assign tick = en && (r_cnt == c_LAST);

    // Next phase: restart wins, otherwise advance only on enabled cycles
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (restart) begin
            w_cnt_nxt = '0;
        end else if (en) begin
            w_cnt_nxt = (r_cnt == c_LAST) ? '0 : (r_cnt + c_ONE);
        end
    end

    // Phase register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

endmodule : tick_prescaler
`default_nettype wire

// File: rtl/mod_counter.sv
`default_nettype none
// ============================================================================
//  Module      : mod_counter
//  Description : Modulo up/down counter with enable, synchronous clear and
//                load, wrap or saturate at range ends and a registered
//                terminal-count pulse aligned with the new count.
//                Optional feature macro: MOD_COUNTER_PRESCALE_EN (inserts a
//                PRESCALE-cycle prescaler in front of the step enable).
//  Revision    : 1.0 - initial release
// ============================================================================
module mod_counter
    import counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MODULO   = 16,
    parameter int SATURATE = 0,
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc
);

    // Reject illegal configurations at elaboration time
    generate
        if ((MODULO < 2) || (longint'(MODULO) > (longint'(1) << WIDTH))) begin : g_bad_modulo
            $error("mod_counter: MODULO out of range 2..2**WIDTH");
        end
        if (PRESCALE < 1) begin : g_bad_prescale
            $error("mod_counter: PRESCALE must be at least 1");
        end
        if ((SATURATE != MOD_COUNTER_MODE_WRAP) && (SATURATE != MOD_COUNTER_MODE_SAT)) begin : g_bad_saturate
            $error("mod_counter: SATURATE must be 0 or 1");
        end
    endgenerate

    localparam logic [WIDTH-1:0] c_MAX     = WIDTH'(MODULO - 1);
    localparam logic [WIDTH-1:0] c_ONE     = WIDTH'(1);
    localparam logic [WIDTH:0]   c_MOD_EXT = (WIDTH + 1)'(MODULO);
    localparam bit               c_SAT     = (SATURATE == MOD_COUNTER_MODE_SAT);

    logic [WIDTH-1:0] r_q;
    logic             r_tc;
    logic [WIDTH-1:0] w_q_nxt;
    logic             w_tc_nxt;
    logic             w_step;
    logic             w_restart;

    // clear and load both restart the step phase
    assign w_restart = clear | load;

`ifdef MOD_COUNTER_PRESCALE_EN
    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .restart (w_restart),
        .tick    (w_step)
    );
`else
    assign w_step = en;
`endif

    // Next count and terminal-count: clear > load > step > hold
    always_comb begin
        w_q_nxt  = r_q;
        w_tc_nxt = 1'b0;
        if (clear) begin
            w_q_nxt = '0;
        end else if (load) begin
            // Zero-extend so MODULO == 2**WIDTH never clamps
            w_q_nxt = ({1'b0, load_val} >= c_MOD_EXT) ? c_MAX : load_val;
        end else if (w_step) begin
            if (up) begin
                if (r_q == c_MAX) begin
                    w_tc_nxt = 1'b1;
                    w_q_nxt  = c_SAT ? r_q : '0;
                end else begin
                    w_q_nxt  = r_q + c_ONE;
                end
            end else begin
                if (r_q == '0) begin
                    w_tc_nxt = 1'b1;
                    w_q_nxt  = c_SAT ? r_q : c_MAX;
                end else begin
                    w_q_nxt  = r_q - c_ONE;
                end
            end
        end
    end

    // Count and pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q  <= '0;
            r_tc <= 1'b0;
        end else begin
            r_q  <= w_q_nxt;
            r_tc <= w_tc_nxt;
        end
    end

    assign q  = r_q;
    assign tc = r_tc;

    // Terminal count implies the count sits at a range end
    always_ff @(posedge clk) begin
        if (rst_n && r_tc) begin
            assert ((r_q == '0) || (r_q == c_MAX))
                else $error("mod_counter: tc high away from a range end");
        end
    end

endmodule : mod_counter
`default_nettype wire

// File: tb/tb_mod_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mod_counter
//  Description : Scoreboard bench for mod_counter. Instance 0 wraps, instance
//                1 saturates, instance 2 (prescaler build only) uses
//                PRESCALE=3. All use WIDTH=4, MODULO=10.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mod_counter;

    typedef struct {
        int         sel;
        logic [3:0] q;
        logic       tc;
        string      name;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       en_s  [3];
    logic       up_s  [3];
    logic       clr_s [3];
    logic       ld_s  [3];
    logic [3:0] lv_s  [3];
    logic [3:0] q_s   [3];
    logic       tc_s  [3];

    exp_t sb[$];
    int   n_cmp;
    int   n_bad;

    logic [3:0] s1_q [12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};
    logic [3:0] s3_q [12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd9, 4'd9, 4'd9};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mod_counter #(.WIDTH(4), .MODULO(10), .SATURATE(0), .PRESCALE(1)) dut_wrap (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en_s[0]),
        .up       (up_s[0]),
        .clear    (clr_s[0]),
        .load     (ld_s[0]),
        .load_val (lv_s[0]),
        .q        (q_s[0]),
        .tc       (tc_s[0])
    );

    mod_counter #(.WIDTH(4), .MODULO(10), .SATURATE(1), .PRESCALE(1)) dut_sat (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en_s[1]),
        .up       (up_s[1]),
        .clear    (clr_s[1]),
        .load     (ld_s[1]),
        .load_val (lv_s[1]),
        .q        (q_s[1]),
        .tc       (tc_s[1])
    );

`ifdef MOD_COUNTER_PRESCALE_EN
    mod_counter #(.WIDTH(4), .MODULO(10), .SATURATE(0), .PRESCALE(3)) dut_pre (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en_s[2]),
        .up       (up_s[2]),
        .clear    (clr_s[2]),
        .load     (ld_s[2]),
        .load_val (lv_s[2]),
        .q        (q_s[2]),
        .tc       (tc_s[2])
    );
`else
    assign q_s[2]  = 4'd0;
    assign tc_s[2] = 1'b0;
`endif

    task automatic check(input string nm, input logic [3:0] aq, input logic atc,
                         input logic [3:0] eq, input logic etc);
        n_cmp++;
        if ((aq !== eq) || (atc !== etc)) begin
            n_bad++;
            $display("FAIL %s: got q=%0d tc=%0b, expected q=%0d tc=%0b", nm, aq, atc, eq, etc);
        end
    endtask

    // Drive one cycle of control for an instance and queue its expected result
    task automatic step(input int sel, input logic e, input logic u, input logic c,
                        input logic l, input logic [3:0] lv,
                        input logic [3:0] eq, input logic etc, input string nm);
        exp_t x;
        @(negedge clk);
        en_s[sel]  = e;
        up_s[sel]  = u;
        clr_s[sel] = c;
        ld_s[sel]  = l;
        lv_s[sel]  = lv;
        x.sel  = sel;
        x.q    = eq;
        x.tc   = etc;
        x.name = nm;
        sb.push_back(x);
    endtask

    task automatic idle(input int sel);
        @(negedge clk);
        en_s[sel]  = 1'b0;
        up_s[sel]  = 1'b0;
        clr_s[sel] = 1'b0;
        ld_s[sel]  = 1'b0;
        lv_s[sel]  = 4'd0;
    endtask

    // Monitor: each rising edge retires the oldest queued expectation
    always @(posedge clk) begin
        exp_t m;
        #1;
        if (sb.size() > 0) begin
            m = sb.pop_front();
            check(m.name, q_s[m.sel], tc_s[m.sel], m.q, m.tc);
        end
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            en_s[i] = 1'b0; up_s[i] = 1'b0; clr_s[i] = 1'b0; ld_s[i] = 1'b0; lv_s[i] = 4'd0;
        end

        repeat (2) @(posedge clk);
        #1;
        check("reset_wrap", q_s[0], tc_s[0], 4'd0, 1'b0);
        check("reset_sat",  q_s[1], tc_s[1], 4'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Wrap counting up through the modulus
        for (int i = 0; i < 12; i++)
            step(0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, s1_q[i], (i == 9), "s1_up");

        // Down from zero wraps to MODULO-1
        step(0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, "s2_clear");
        step(0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd9, 1'b1, "s2_dn_wrap");
        step(0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd8, 1'b0, "s2_dn_8");
        step(0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd7, 1'b0, "s2_dn_7");

        // Load clamping and priority
        step(0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd13, 4'd9, 1'b0, "s4_load_clamp13");
        step(0, 1'b1, 1'b1, 1'b1, 1'b1, 4'd7,  4'd0, 1'b0, "s4_clear_prio");
        step(0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd10, 4'd9, 1'b0, "s4_load_clamp10");
        step(0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0,  4'd0, 1'b1, "s4_wrap_after_load");
        step(0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd5,  4'd5, 1'b0, "s4_load_over_en");
        step(0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0,  4'd5, 1'b0, "s4_hold");
        step(0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0,  4'd6, 1'b0, "s5_to6");
        idle(0);

        // Asynchronous reset between edges
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("s5_async_reset", q_s[0], tc_s[0], 4'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("s5_reset_hold", q_s[0], tc_s[0], 4'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd1, 1'b0, "s5_resume");
        idle(0);

        // Saturating instance
        for (int i = 0; i < 12; i++)
            step(1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, s3_q[i], (i >= 9), "s3_sat_up");
        step(1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, "s3_clear");
        step(1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1, "s3_sat_dn");
        step(1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1, "s3_sat_dn_again");
        step(1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd1, 1'b0, "s3_up_off_floor");
        idle(1);

`ifdef MOD_COUNTER_PRESCALE_EN
        // Prescaled instance: one step per three enabled cycles, phase kept across en=0
        step(2, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, "s6_pre_c1");
        step(2, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, "s6_pre_c2");
        step(2, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd1, 1'b0, "s6_pre_c3");
        step(2, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd1, 1'b0, "s6_pre_c4");
        step(2, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd1, 1'b0, "s6_pre_c5");
        step(2, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd2, 1'b0, "s6_pre_c6");
        step(2, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd2, 1'b0, "s6_pre_c7");
        step(2, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd2, 1'b0, "s6_pre_off1");
        step(2, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd2, 1'b0, "s6_pre_off2");
        step(2, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd2, 1'b0, "s6_pre_c8");
        step(2, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd3, 1'b0, "s6_pre_c9");
        idle(2);
`endif

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
        #2;
        if (sb.size() > 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_mod_counter
`default_nettype wire
